imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the pipelined CPU. Accepts a byte stream carrying a length header and program image, packs bytes into 32-bit words, and issues single-cycle writes into the instruction RAM that the fetch stage reads by word address. Holds the CPU in stall while loading and releases it on completion. Sits between the host/UART byte source and the write port of the instruction memory.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity is 2**ADDR_W words.
- clk  input  1  system clock.
- rst_n  input  1  reset: rst_n, asynchronous, active-low; clock clk.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- s_data  input  8  incoming byte.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts a byte this cycle; a byte transfers when s_valid && s_ready.
- we  output  1  instruction-RAM write strobe, one cycle per word.
- waddr  output  ADDR_W  word address of the write.
- wdata  output  32  word written.
- cpu_hold  output  1  stall/hold request to the CPU; high while a load is in progress.
- done  output  1  level; high in DONE.
- error  output  1  level; high in ERR.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CKSUM (only with the macro), DONE, ERR.
- IDLE/DONE/ERR + start -> LEN_HI. Clear word counter, byte counter, and checksum. start in any other state is ignored.
- LEN_HI: accept a byte into len[15:8] -> LEN_LO.
- LEN_LO: accept a byte into len[7:0]. If len > 2**ADDR_W -> ERR. If len == 0 -> CKSUM when the macro is on, otherwise DONE. Else -> DATA.
- DATA: bytes are big-endian within a word; the first byte goes to wdata[31:24].
  - The 4th byte completes the word. The word is written at waddr = word index, starting at 0.
  - After the word with index len-1 -> CKSUM when the macro is on, otherwise DONE.
- s_ready = 1 only in LEN_HI, LEN_LO, DATA and CKSUM, and is a registered state decode.
- cpu_hold = 1 in LEN_HI, LEN_LO, DATA and CKSUM. It also stays 1 through the cycle of the final we.
- cpu_hold = 0 in IDLE, DONE and ERR.
- The word counter is ADDR_W+1 bits, so len = 2**ADDR_W is legal and does not wrap. waddr is its low ADDR_W bits.
- Stalls: s_valid low in mid-word leaves the partial word and counters unchanged indefinitely.

## Timing
- Reset values: s_ready=0, we=0, waddr=0, wdata=0, cpu_hold=0, done=0, error=0; state IDLE.
- start is sampled at posedge. s_ready and cpu_hold rise on the next cycle.
- we is registered and pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. waddr and wdata are stable while we is high and hold their values afterwards.
- A back-to-back stream gives at most one write every 4 cycles, so there are never overlapping writes.
- done/error rise in the cycle after the last accepted byte, or after the length byte that triggers ERR. They stay high until the next start or reset.
- Reset mid-load aborts immediately: cpu_hold drops and the partially written RAM contents are left as they are.
- Bytes presented while s_ready=0 are not consumed.

## Configuration
- IMEM_LOADER_CKSUM_EN defined:
  - After the last data word, one extra byte is accepted in CKSUM.
  - The running checksum is the XOR of every byte from LEN_HI onward, including both length bytes.
  - Received byte == running XOR -> DONE; otherwise -> ERR. The data words are already written in either case.
- Not defined: the CKSUM state and the XOR register are absent; the last data word -> DONE.

## Structure
- Shared package imem_pkg holds:
  - the state encoding (3-bit localparams);
  - LEN_W=16;
  - the byte-order constant;
  - the shared instruction-memory ADDR_W default, so it matches the fetch stage.
- One natural sub-module: imem_word_packer. It is a 4-byte shift register with a 2-bit byte counter that emits word_valid and word. The FSM, counters and checksum stay in imem_loader.

## Test plan
- Load with len=2, bytes 00 02 DE AD BE EF 12 34 56 78, no gaps:
  - we at word 0 with DEADBEEF and at word 1 with 12345678, each one cycle;
  - done=1 and cpu_hold=0 after the last byte.
- Same stream with s_valid dropped for 5 cycles after byte 6:
  - identical writes, only delayed;
  - no spurious we during the gap.
- len=0x0401 with ADDR_W=10: error=1 after the length byte, no we, cpu_hold=0.
- With IMEM_LOADER_CKSUM_EN and len=1, bytes 00 01 11 22 33 44:
  - trailing byte 0x45 -> done;
  - trailing byte 0x00 -> error, with word 0 = 11223344 written in both cases.
- rst_n asserted after 2 data bytes, then start and a new len=1 stream AABBCCDD: a single write of AABBCCDD to word 0.
- start pulsed while in DATA: ignored, and the load completes normally.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Build option: IMEM_LOADER_CKSUM_EN adds the trailing XOR checksum state.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam bit          BIG_ENDIAN  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CKSUM_EN
    ST_CKSUM  = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // States in which a load is in progress and bytes are consumed.
  function automatic logic is_busy(input state_e s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream into 32-bit words; emits a one-cycle registered word_valid
// with the completed word, which is then held until the next word completes.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [1:0]        byte_cnt,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned SR_W = 3 * BYTE_W;

  logic [1:0]        cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (clear) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (byte_valid) begin
      sr_d  = {sr_q[SR_W-BYTE_W-1:0], byte_in};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        word_valid_d = 1'b1;
        // sr_q holds the first byte in its top lane
        if (BIG_ENDIAN) word_d = {sr_q, byte_in};
        else            word_d = {byte_in, sr_q[7:0], sr_q[15:8], sr_q[23:16]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sr_q         <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length header + image bytes -> word writes.
// Build option: IMEM_LOADER_CKSUM_EN appends a trailing XOR checksum byte check.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned   CNT_W   = ADDR_W + 1;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1) << ADDR_W;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CKSUM;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              s_ready_q, s_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [BYTE_W-1:0] cksum_q, cksum_d;
`endif

  logic              accept_c;
  logic              pack_valid_c;
  logic              pack_clear_c;
  logic              word_last_c;
  logic [1:0]        byte_cnt;
  logic [LEN_W-1:0]  len_full_c;
  logic [CNT_W-1:0]  word_cnt_inc_c;

  assign accept_c       = s_valid && s_ready_q;
  assign pack_valid_c   = accept_c && (state_q == ST_DATA);
  assign pack_clear_c   = start && !is_busy(state_q);
  assign word_last_c    = pack_valid_c && (byte_cnt == 2'd3);
  assign len_full_c     = {len_q[LEN_W-1:BYTE_W], s_data};
  assign word_cnt_inc_c = word_cnt_q + CNT_W'(1);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear_c),
    .byte_valid (pack_valid_c),
    .byte_in    (s_data),
    .byte_cnt   (byte_cnt),
    .word_valid (we),
    .word       (wdata)
  );

  // Next-state, counters and registered output decode.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    waddr_d    = waddr_q;
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_d    = cksum_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          word_cnt_d = '0;
        end
      end
      ST_LEN_HI: begin
        if (accept_c) begin
          len_d[LEN_W-1:BYTE_W] = s_data;
          state_d               = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept_c) begin
          len_d = len_full_c;
          if ({1'b0, len_full_c} > MAX_LEN) state_d = ST_ERR;
          else if (len_full_c == '0)        state_d = ST_AFTER_DATA;
          else                              state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_last_c) begin
          word_cnt_d = word_cnt_inc_c;
          waddr_d    = word_cnt_q[ADDR_W-1:0];
          if (LEN_W'(word_cnt_inc_c) == len_q) state_d = ST_AFTER_DATA;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (accept_c) state_d = (s_data == cksum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef IMEM_LOADER_CKSUM_EN
    // Running XOR covers both length bytes and every data byte.
    if (pack_clear_c)                          cksum_d = '0;
    else if (accept_c && state_q != ST_CKSUM)  cksum_d = cksum_q ^ s_data;
`endif

    s_ready_d  = is_busy(state_d);
    cpu_hold_d = is_busy(state_d) || word_last_c;
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      waddr_q    <= '0;
      s_ready_q  <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      waddr_q    <= waddr_d;
      s_ready_q  <= s_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign s_ready  = s_ready_q;
  assign waddr    = waddr_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and consumed by an independent write monitor.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned AW   = 10;
  localparam int          MAXW = 1 << AW;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready, we, cpu_hold, done, error;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  int            n_cmp = 0;
  int            n_bad = 0;
  wr_t           exp_q[$];
  logic [31:0]   load_words[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(we), 64'(0));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", 64'(waddr), 64'(e.a));
        check("wdata", 64'(wdata), 64'(e.d));
        check("hold_during_we", 64'(cpu_hold), 64'(1));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      start   = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit st);
    int guard = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    start   = st;
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", 64'(s_ready), 64'(1));
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // ck: -1 correct checksum, -2 wrong checksum, >=0 literal trailing byte.
  task automatic run_load(input int len, input bit rnd_gaps, input int gap_at,
                          input int gap_len, input int start_at, input int ck);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    bit          exp_err;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]  x;
    logic [7:0]  cb;
`endif
    bytes.push_back(8'(len >> 8));
    bytes.push_back(8'(len));
    exp_err = (len > MAXW);
    if (!exp_err) begin
      for (int i = 0; i < len; i++) begin
        w = load_words[i];
        exp_q.push_back('{AW'(i), w});
        for (int k = 3; k >= 0; k--) bytes.push_back(w[8*k +: 8]);
      end
    end
`ifdef IMEM_LOADER_CKSUM_EN
    if (!exp_err) begin
      x = 8'h00;
      foreach (bytes[i]) x ^= bytes[i];
      if (ck >= 0)       cb = 8'(ck);
      else if (ck == -2) cb = ~x;
      else               cb = x;
      exp_err = (cb != x);
      bytes.push_back(cb);
    end
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", 64'(s_ready), 64'(1));
    check("hold_after_start", 64'(cpu_hold), 64'(1));
    foreach (bytes[i]) begin
      if (i == gap_at) idle(gap_len);
      else if (rnd_gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send_byte(bytes[i], i == start_at);
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("done", 64'(done), 64'(!exp_err));
    check("error", 64'(error), 64'(exp_err));
    @(negedge clk);
    check("hold_released", 64'(cpu_hold), 64'(0));
    check("ready_low_at_end", 64'(s_ready), 64'(0));
    check("done_held", 64'(done), 64'(!exp_err));
    check("writes_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic fill_random(input int n);
    load_words.delete();
    for (int i = 0; i < n; i++) load_words.push_back($urandom());
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_we", 64'(we), 64'(0));
    check("rst_waddr", 64'(waddr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    load_words = '{32'hDEADBEEF, 32'h12345678};
    run_load(2, 1'b0, -1, 0, -1, -1);
    run_load(2, 1'b0, 6, 5, -1, -1);

    run_load(16'h0401, 1'b0, -1, 0, -1, -1);
    run_load(0, 1'b0, -1, 0, -1, -1);

`ifdef IMEM_LOADER_CKSUM_EN
    load_words = '{32'h11223344};
    run_load(1, 1'b0, -1, 0, -1, 8'h45);
    run_load(1, 1'b0, -1, 0, -1, 8'h00);
`endif

    // Reset in the middle of a word, then a fresh load.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("abort_hold", 64'(cpu_hold), 64'(0));
    check("abort_ready", 64'(s_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    load_words = '{32'hAABBCCDD};
    run_load(1, 1'b0, -1, 0, -1, -1);

    fill_random(3);
    run_load(3, 1'b0, -1, 0, 5, -1);

    fill_random(MAXW);
    run_load(MAXW, 1'b0, -1, 0, -1, -1);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 1025 + int'($urandom_range(0, 500))
                                         : int'($urandom_range(0, 12));
      fill_random(len > MAXW ? 0 : len);
      run_load(len, 1'b1, -1, 0, -1, ($urandom_range(0, 3) == 0) ? -2 : -1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
